// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
//   PC_SRC_W : width of the pc_src status field
//   NPC_*    : encodings reported on pc_src for each pc load source
package pc_pkg;

   localparam int PC_SRC_W = 3;

   localparam logic [PC_SRC_W-1:0] NPC_RST   = 3'd0;
   localparam logic [PC_SRC_W-1:0] NPC_SEQ   = 3'd1;
   localparam logic [PC_SRC_W-1:0] NPC_HOLD  = 3'd2;
   localparam logic [PC_SRC_W-1:0] NPC_RAS   = 3'd3;
   localparam logic [PC_SRC_W-1:0] NPC_REDIR = 3'd4;
   localparam logic [PC_SRC_W-1:0] NPC_TRAP  = 3'd5;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk, rst   : clock, asynchronous active-low reset (pointer/count only)
//   push       : write push_data as the new top
//   pop        : discard the top (ignored when empty)
//   flush      : clear the stack; overrides push/pop
//   push_data  : address to push
//   top        : entry[ptr-1], valid only when !empty
//   empty/full : count == 0 / count == DEPTH
module ras_stack #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   ptr, ptr_n, top_idx, wr_idx;
   logic [CW-1:0]   cnt, cnt_n;
   logic            wr_en;
   logic            do_pop;

   // ptr is the next free slot; DEPTH is a power of two so the pointer wraps
   // for free in both directions.
   assign top_idx = ptr - PW'(1);
   assign top     = mem[top_idx];
   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop && !empty;

   always_comb begin
      ptr_n  = ptr;
      cnt_n  = cnt;
      wr_en  = 1'b0;
      wr_idx = ptr;
      if (flush) begin
         ptr_n = '0;
         cnt_n = '0;
      end else if (push && do_pop) begin
         // Simultaneous call/return: replace the top in place.
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (push) begin
         // A push when full overwrites the oldest slot; count saturates.
         wr_en = 1'b1;
         ptr_n = ptr + PW'(1);
         if (!full) cnt_n = cnt + CW'(1);
      end else if (do_pop) begin
         ptr_n = top_idx;
         cnt_n = cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
         cnt <= '0;
      end else begin
         ptr <= ptr_n;
         cnt <= cnt_n;
      end
   end

   // Entry storage carries no reset; contents are only read while non-empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with return-address prediction.
//   clk, rst                      : clock, asynchronous active-low reset
//   stall                         : hold pc
//   redirect_valid/target         : resolved mispredict redirect
//   trap_valid/target             : exception/interrupt vector
//   ras_push/ras_push_addr        : decode saw a call
//   ras_pop                       : decode saw a return; predict from RAS
//   pc                            : registered fetch address
//   pc_plus                       : pc + ILEN_BYTES
//   pc_src                        : source of the most recent pc load
//   ras_empty/ras_full            : RAS occupancy flags
//   align_err                     : accepted target had low bits set (one cycle)
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              ILEN_BYTES   = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_target,
   input  logic                trap_valid,
   input  logic [XLEN-1:0]     trap_target,
   input  logic                ras_push,
   input  logic [XLEN-1:0]     ras_push_addr,
   input  logic                ras_pop,
   output logic [XLEN-1:0]     pc,
   output logic [XLEN-1:0]     pc_plus,
   output logic [PC_SRC_W-1:0] pc_src,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                align_err
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

   logic [XLEN-1:0]     ras_top;
   logic                ras_en;
   logic [XLEN-1:0]     npc, target;
   logic [PC_SRC_W-1:0] npc_src;
   logic                npc_err, use_target;

   // Trap flushes the RAS outright; a stall freezes it unless a redirect
   // outranks the stall, in which case decode's ops still land.
   assign ras_en = !trap_valid && (redirect_valid || !stall);

   ras_stack #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push && ras_en),
      .pop       (ras_pop && ras_en),
      .flush     (trap_valid),
      .push_data (ras_push_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   assign pc_plus = pc + XLEN'(ILEN_BYTES);

   always_comb begin
      target     = '0;
      use_target = 1'b0;
      npc        = pc_plus;
      npc_src    = NPC_SEQ;
      if (trap_valid) begin
         target     = trap_target;
         use_target = 1'b1;
         npc_src    = NPC_TRAP;
      end else if (redirect_valid) begin
         target     = redirect_target;
         use_target = 1'b1;
         npc_src    = NPC_REDIR;
      end else if (stall) begin
         npc     = pc;
         npc_src = NPC_HOLD;
      end else if (ras_pop && !ras_empty) begin
         // The RAS entry read here is the pre-update top, so a same-cycle
         // push+pop predicts the old return address.
         target     = ras_top;
         use_target = 1'b1;
         npc_src    = NPC_RAS;
      end
      npc_err = use_target && |(target & ALIGN_MASK);
      if (use_target) npc = target & ~ALIGN_MASK;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= RESET_VECTOR;
         pc_src    <= NPC_RST;
         align_err <= 1'b0;
      end else begin
         pc        <= npc;
         pc_src    <= npc_src;
         align_err <= npc_err;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   import pc_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect_valid, trap_valid, ras_push, ras_pop;
   logic [31:0] redirect_target, trap_target, ras_push_addr;
   logic [31:0] pc, pc_plus;
   logic [2:0]  pc_src;
   logic        ras_empty, ras_full, align_err;

   int n_chk = 0;
   int n_fail = 0;

   // Reference state: RAS kept as a bounded list, newest at the back.
   logic [31:0] m_pc;
   logic [2:0]  m_src;
   logic        m_err;
   logic [31:0] m_ras[$];

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .ILEN_BYTES(4), .RAS_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_target     (trap_target),
      .ras_push        (ras_push),
      .ras_push_addr   (ras_push_addr),
      .ras_pop         (ras_pop),
      .pc              (pc),
      .pc_plus         (pc_plus),
      .pc_src          (pc_src),
      .ras_empty       (ras_empty),
      .ras_full        (ras_full),
      .align_err       (align_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = 32'h0;
      m_src = NPC_RST;
      m_err = 1'b0;
      m_ras.delete();
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},      pc,        m_pc);
      check({tag, ".pc_plus"}, pc_plus,   m_pc + 32'd4);
      check({tag, ".src"},     {29'd0, pc_src}, {29'd0, m_src});
      check({tag, ".err"},     {31'd0, align_err}, {31'd0, m_err});
      check({tag, ".empty"},   {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
      check({tag, ".full"},    {31'd0, ras_full},  {31'd0, m_ras.size() == DEPTH});
   endtask

   // Apply one cycle of inputs (called just after a rising edge), advance the
   // model by the architectural rules, then compare after the next edge.
   task automatic step(input string tag,
                       input bit tr, input logic [31:0] tt,
                       input bit rd, input logic [31:0] rt,
                       input bit st, input bit pu, input logic [31:0] pa, input bit po);
      logic [31:0] t;
      bit hit;
      trap_valid = tr; trap_target = tt;
      redirect_valid = rd; redirect_target = rt;
      stall = st; ras_push = pu; ras_push_addr = pa; ras_pop = po;
      hit = po && (m_ras.size() > 0);
      if (tr) begin
         t = tt; m_src = NPC_TRAP;
         m_ras.delete();
      end else begin
         if (rd)       begin t = rt; m_src = NPC_REDIR; end
         else if (st)  begin t = m_pc; m_src = NPC_HOLD; end
         else if (hit) begin t = m_ras[$]; m_src = NPC_RAS; end
         else          begin t = m_pc + 32'd4; m_src = NPC_SEQ; end
         if (rd || !st) begin
            if (pu && hit) m_ras[m_ras.size()-1] = pa;
            else if (pu) begin
               m_ras.push_back(pa);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (hit) void'(m_ras.pop_back());
         end
      end
      m_err = (m_src inside {NPC_TRAP, NPC_REDIR, NPC_RAS}) && (t[1:0] != 2'b00);
      m_pc  = (m_src inside {NPC_TRAP, NPC_REDIR, NPC_RAS}) ? {t[31:2], 2'b00} : t;
      @(posedge clk); #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      {stall, redirect_valid, trap_valid, ras_push, ras_pop} = '0;
      redirect_target = '0; trap_target = '0; ras_push_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;

      // Sequential after release
      idle("seq1"); check("seq1.k", pc, 32'h4);
      idle("seq2"); idle("seq3"); check("seq3.k", pc, 32'hC);

      // Stall hold, then redirect overrides stall
      step("goto10", 0, 0, 1, 32'h10, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 1, 0, 0, 0);
      check("stall.k", pc, 32'h10);
      step("stall_redir", 0, 0, 1, 32'h80, 1, 0, 0, 0);
      check("stall_redir.k", pc, 32'h80);

      // Priority: trap wins and flushes RAS
      step("push50", 0, 0, 0, 0, 0, 1, 32'h50, 0);
      step("prio", 1, 32'h100, 1, 32'h200, 0, 0, 0, 1);
      check("prio.k", pc, 32'h100);
      check("prio.empty.k", {31'd0, ras_empty}, 32'd1);

      // Overfill then drain
      for (int i = 0; i < 5; i++) step("push", 0, 0, 0, 0, 0, 1, 32'h14 + 32'h10 * i, 0);
      check("full.k", {31'd0, ras_full}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         step("pop", 0, 0, 0, 0, 0, 0, 0, 1);
         check("pop.k", pc, 32'h54 - 32'h10 * i);
      end
      step("pop_empty", 0, 0, 0, 0, 0, 0, 0, 1);
      check("pop_empty.k", {29'd0, pc_src}, {29'd0, NPC_SEQ});

      // Push+pop same cycle replaces top
      step("p34", 0, 0, 0, 0, 0, 1, 32'h34, 0);
      step("p44", 0, 0, 0, 0, 0, 1, 32'h44, 0);
      step("pushpop", 0, 0, 0, 0, 0, 1, 32'h99, 1);
      check("pushpop.k", pc, 32'h44);
      step("pop99", 0, 0, 0, 0, 0, 0, 0, 1);
      check("pop99.k", pc, 32'h98);

      // Misaligned redirect, then wrap
      step("align", 0, 0, 1, 32'h103, 0, 0, 0, 0);
      check("align.k", {31'd0, align_err}, 32'd1);
      idle("align_clr");
      step("gotoFFC", 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      idle("wrap"); check("wrap.k", pc, 32'h0);

      // Asynchronous reset mid-run
      idle("pre_rst");
      rst = 1'b0; #1;
      model_reset();
      check_all("async_rst");
      #2; rst = 1'b1;
      @(posedge clk); #1;
      m_pc = 32'h4; m_src = NPC_SEQ;
      check_all("post_rst");

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step("rand",
              ($urandom_range(0, 19) == 0), $urandom(),
              ($urandom_range(0, 7) == 0),  $urandom(),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 3) == 0),  $urandom(),
              ($urandom_range(0, 2) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
